// File: rtl/ram_sdp_param_if.sv
// Bus bundle for ram_sdp_param: the write port, the read request and the read result.
// The client drives the master side and the RAM implements the slave side.
interface ram_sdp_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic                  we;
  logic [DATA_W/8-1:0]   wr_be;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  busy;

  modport master (
    output we, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  we, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ram_sdp_param.sv
// Simple dual-port RAM: per-byte write enables, write-first collision bypass,
// optional output register and a post-reset sequencer that zeroes every word.
module ram_sdp_param #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 16,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst,
  ram_sdp_param_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_READY = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_clr_addr;

  logic               w_wr_en;
  logic [NB-1:0]      w_wr_be;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [DATA_W-1:0]  w_wr_data;
  logic               w_rd_acc;

  logic               r_v1;
  logic [NB-1:0]      r_byp_be;
  logic [DATA_W-1:0]  r_byp_data;
  logic [DATA_W-1:0]  w_s1_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RST_STATE;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_CLEAR && r_clr_addr == {ADDR_W{1'b1}}) w_state_next = S_READY;
  end

  // Output logic: the sequencer owns the write port while clearing
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_be   = '0;
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_acc  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_wr_en   = !rst;
        w_wr_be   = '1;
        w_wr_addr = r_clr_addr;
      end
      default: begin
        w_wr_en   = bus.we && !rst;
        w_wr_be   = bus.wr_be;
        w_wr_addr = bus.wr_addr;
        w_wr_data = bus.wr_data;
        w_rd_acc  = bus.rd_en && !rst;
      end
    endcase
  end

  assign bus.busy = (r_state == S_CLEAR);

  // Resetting the bypass to "all lanes from zero data" forces rd_data to 0
  // without needing a reset on the array's read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_byp_be   <= '1;
      r_byp_data <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_byp_be   <= (w_wr_en && w_wr_addr == bus.rd_addr) ? w_wr_be : '0;
        r_byp_data <= w_wr_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
        if (w_wr_en && w_wr_be[gi]) r_mem[w_wr_addr] <= w_wr_data[8*gi +: 8];
        if (w_rd_acc) r_q <= r_mem[bus.rd_addr];
      end

      assign w_s1_data[8*gi +: 8] = r_byp_be[gi] ? r_byp_data[8*gi +: 8] : r_q;
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] r_out_data;
      logic              r_out_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= r_v1;
          if (r_v1) r_out_data <= w_s1_data;
        end
      end

      assign bus.rd_data  = r_out_data;
      assign bus.rd_valid = r_out_valid;
    end else begin : g_noreg
      assign bus.rd_data  = w_s1_data;
      assign bus.rd_valid = r_v1;
    end
  endgenerate
endmodule

// File: tb/tb_ram_sdp_param.sv
// Bench for ram_sdp_param: two instances (OUT_REG 0 and 1) share one stimulus
// stream; a word-level memory model predicts every output each cycle.
module tb_ram_sdp_param;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  be = '0;
  logic [3:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  raddr = '0;

  int checks = 0;
  int errors = 0;

  ram_sdp_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  ram_sdp_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.we = we;       assign bus1.we = we;
  assign bus0.wr_be = be;    assign bus1.wr_be = be;
  assign bus0.wr_addr = waddr; assign bus1.wr_addr = waddr;
  assign bus0.wr_data = wdata; assign bus1.wr_data = wdata;
  assign bus0.rd_en = rd_en; assign bus1.rd_en = rd_en;
  assign bus0.rd_addr = raddr; assign bus1.rd_addr = raddr;

  ram_sdp_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  ram_sdp_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: array contents, remaining clear cycles, expected outputs.
  logic [15:0] m [DEPTH];
  int          busy_left = 0;
  logic        e0v = 1'b0, e1v = 1'b0;
  logic [15:0] e0d = '0, e1d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] mask;
    logic [15:0] rd;
    logic        n1v;
    logic [15:0] n1d;
    @(posedge clk);
    mask = {{8{be[1]}}, {8{be[0]}}};
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      busy_left = DEPTH;
      e0v = 1'b0; e0d = '0; e1v = 1'b0; e1d = '0;
    end else begin
      n1v = e0v;
      n1d = e0v ? e0d : e1d;
      if (busy_left > 0) begin
        busy_left--;
        e0v = 1'b0;
      end else begin
        e0v = rd_en;
        if (rd_en) begin
          rd = m[raddr];
          if (we && waddr == raddr) rd = (rd & ~mask) | (wdata & mask);
          e0d = rd;
        end
        if (we) m[waddr] = (m[waddr] & ~mask) | (wdata & mask);
      end
      e1v = n1v;
      e1d = n1d;
    end
    #1;
    chk("busy0", 32'(bus0.busy), 32'(busy_left > 0));
    chk("busy1", 32'(bus1.busy), 32'(busy_left > 0));
    chk("valid0", 32'(bus0.rd_valid), 32'(e0v));
    chk("data0", 32'(bus0.rd_data), 32'(e0d));
    chk("valid1", 32'(bus1.rd_valid), 32'(e1v));
    chk("data1", 32'(bus1.rd_data), 32'(e1d));
  endtask

  task automatic idle();
    we = 1'b0; be = '0; waddr = '0; wdata = '0; rd_en = 1'b0; raddr = '0;
  endtask

  // Counts busy-high cycles starting from the sample right after the reset edge.
  task automatic count_busy(input string name);
    int cnt = 0;
    for (int k = 0; k < 40 && bus0.busy; k++) begin
      cnt++;
      tick();
    end
    chk(name, 32'(cnt), 32'd16);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        rd_en;
    logic [3:0]  raddr;
    logic        ev;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int vcnt;
    int seq[$];
    logic        pv;
    logic [15:0] pd;

    vecs[0] = '{1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, 4'd0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, 4'd0, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 16'hAB34};
    vecs[3] = '{1'b1, 2'b11, 4'd5, 16'h5566, 1'b0, 4'd0, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 2'b10, 4'd5, 16'h99AA, 1'b1, 4'd5, 1'b1, 16'h9966};
    vecs[5] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 16'h9966};
    vecs[6] = '{1'b1, 2'b00, 4'd5, 16'hFFFF, 1'b1, 4'd5, 1'b1, 16'h9966};
    vecs[7] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 16'h9966};
    vecs[8] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000};

    // Reset state
    rst = 1'b1; idle();
    tick(); tick();
    chk("rst_busy", 32'(bus0.busy), 32'd1);
    chk("rst_valid0", 32'(bus0.rd_valid), 32'd0);
    chk("rst_data1", 32'(bus1.rd_data), 32'd0);
    $display("reset: busy=%0d rd_valid=%0d", bus0.busy, bus0.rd_valid);

    // Clear length, with requests that must be ignored while busy
    we = 1'b1; be = 2'b11; waddr = 4'd2; wdata = 16'hFFFF; rd_en = 1'b1; raddr = 4'd2;
    rst = 1'b0;
    count_busy("clear_len");
    idle();
    rd_en = 1'b1; raddr = 4'd2;
    tick();
    idle();
    chk("busy_write_ignored", 32'(bus0.rd_data), 32'h0000);
    chk("busy_write_valid", 32'(bus0.rd_valid), 32'd1);
    $display("read addr 2 after clear: %h", bus0.rd_data);
    tick();

    // All words read back as zero, valid for 16 consecutive cycles
    vcnt = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; raddr = 4'(a);
      tick();
      vcnt += int'(bus0.rd_valid);
      chk("clear_data", 32'(bus0.rd_data), 32'h0000);
    end
    idle();
    tick();
    chk("clear_valid_run", 32'(vcnt), 32'd16);
    $display("cleared array read: %0d valid words", vcnt);

    // Byte enables, collision merge, zero-enable write
    pv = 1'b0; pd = '0;
    for (int i = 0; i < 9; i++) begin
      we = vecs[i].we; be = vecs[i].be; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      rd_en = vecs[i].rd_en; raddr = vecs[i].raddr;
      tick();
      chk("vec_valid0", 32'(bus0.rd_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) chk("vec_data0", 32'(bus0.rd_data), 32'(vecs[i].ed));
      chk("vec_valid1", 32'(bus1.rd_valid), 32'(pv));
      if (pv) chk("vec_data1", 32'(bus1.rd_data), 32'(pd));
      $display("vec %0d we=%0d be=%b wa=%0d wd=%h rd=%0d ra=%0d -> v=%0d d=%h",
               i, vecs[i].we, vecs[i].be, vecs[i].waddr, vecs[i].wdata,
               vecs[i].rd_en, vecs[i].raddr, bus0.rd_valid, bus0.rd_data);
      pv = vecs[i].ev; pd = vecs[i].ed;
    end
    idle();

    // Streaming: fill, then read with gaps ahead of addresses 4 and 9
    for (int a = 0; a < DEPTH; a++) begin
      we = 1'b1; be = 2'b11; waddr = 4'(a); wdata = 16'h0100 + 16'(a);
      tick();
    end
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      if (a == 4 || a == 9) seq.push_back(-1);
      seq.push_back(a);
    end
    foreach (seq[k]) begin
      rd_en = (seq[k] >= 0); raddr = (seq[k] >= 0) ? 4'(seq[k]) : 4'd0;
      tick();
      chk("stream_valid", 32'(bus0.rd_valid), 32'(seq[k] >= 0));
      if (seq[k] >= 0) chk("stream_data", 32'(bus0.rd_data), 32'h0100 + 32'(seq[k]));
    end
    idle();
    tick(); tick();
    $display("stream: %0d read slots issued", seq.size());

    // Reset at clear cycle 7 restarts the full sequence
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    count_busy("restart_len");
    $display("mid-clear reset: busy run rechecked");

    // Read dropped when reset coincides with the request (1-cycle instance)
    we = 1'b1; be = 2'b11; waddr = 4'd1; wdata = 16'hBEEF; tick();
    idle(); rd_en = 1'b1; raddr = 4'd1; rst = 1'b1; tick();
    idle();
    chk("drop_valid0", 32'(bus0.rd_valid), 32'd0);
    chk("drop_data0", 32'(bus0.rd_data), 32'd0);
    rst = 1'b0;
    count_busy("drop_clear_len");

    // Read in flight in the output register stage when reset hits
    we = 1'b1; be = 2'b11; waddr = 4'd1; wdata = 16'hBEEF; tick();
    idle(); rd_en = 1'b1; raddr = 4'd1; tick();
    chk("inflight_data0", 32'(bus0.rd_data), 32'hBEEF);
    idle(); rst = 1'b1; tick();
    chk("inflight_valid1", 32'(bus1.rd_valid), 32'd0);
    chk("inflight_data1", 32'(bus1.rd_data), 32'd0);
    rst = 1'b0;
    count_busy("inflight_clear_len");
    $display("reset with read in flight: no valid pulse");

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 500; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      we    = $urandom_range(0, 1) == 1;
      be    = 2'($urandom_range(0, 3));
      waddr = 4'($urandom_range(0, 15));
      wdata = 16'($urandom());
      rd_en = $urandom_range(0, 3) != 0;
      raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; idle();
    tick(); tick();
    $display("random traffic: 500 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_sdp_param.md
# ram_sdp_param

Parametrised simple dual-port synchronous RAM: one write port and one read port on a single clock. It is the next generation of the team's 8-bit × 64K dual-port RAM, generalised in data width and depth. Over that design it adds:
- per-byte write enables;
- an explicit read enable with a `rd_valid` qualifier;
- an optional output register stage;
- a reset-time clear sequencer that zeroes the whole array.

It sits wherever the design needs a scratch or line buffer with deterministic post-reset contents.

## Interface

Parameters:
- `DATA_W`, default 8: word width in bits. Must be a multiple of 8.
- `ADDR_W`, default 16: address width. Depth = 2^ADDR_W words.
- `OUT_REG`, default 0: 0 gives 1-cycle read latency; 1 adds an output register, giving 2-cycle latency.
- `CLEAR_ON_RESET`, default 1: 1 zeroes every word after reset; 0 leaves contents undefined.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `we`, input, 1: write enable.
- `wr_be`, input, DATA_W/8: byte enables for the write. Bit i covers `wr_data[8i+7:8i]`.
- `wr_addr`, input, ADDR_W: write address.
- `wr_data`, input, DATA_W: write data.
- `rd_en`, input, 1: read request.
- `rd_addr`, input, ADDR_W: read address.
- `rd_data`, output, DATA_W: read data. Registered.
- `rd_valid`, output, 1: `rd_data` holds the result of a read request.
- `busy`, output, 1: clear sequence in progress. All requests are ignored while high.

## Operation

- FSM states:
  - `CLEAR`: sequencer owns the write port.
  - `READY`: normal operation.
- On `rst`:
  - State goes to `CLEAR` if `CLEAR_ON_RESET`=1, else `READY`.
  - `clr_addr` = 0.
  - `rd_data` = 0, `rd_valid` = 0, and any pipeline-stage valid is cleared.
  - `busy` = 1 in `CLEAR`, 0 in `READY`.
- `CLEAR`:
  - Each cycle writes all-zero to `mem[clr_addr]`, then increments `clr_addr`.
  - When `clr_addr` = 2^ADDR_W−1 is written, the next state is `READY`.
  - `we` and `rd_en` are ignored. `rd_valid` stays 0.
- `READY`, write:
  - When `we`=1, for each i with `wr_be[i]`=1, byte i of `mem[wr_addr]` = byte i of `wr_data`.
  - Bytes with `wr_be[i]`=0 are unchanged.
  - `we`=1 with `wr_be`=0 is a no-op.
- `READY`, read:
  - When `rd_en`=1, the read is captured.
  - `rd_en`=0: `rd_data` holds its last value and `rd_valid` is deasserted on the corresponding cycle.
- Same-cycle collision (`we`=1, `rd_en`=1, `wr_addr`=`rd_addr`): write-first, merged per byte.
  - Byte i of the read result = `wr_data` byte i if `wr_be[i]`=1.
  - Otherwise byte i = the old `mem` byte.
- Different addresses: the read returns the old array contents. No ordering dependency.
- Write at cycle N to the address read at cycle N−1: does not alter data already captured, including the `OUT_REG` stage.
- Reset asserted mid-`CLEAR`: the sequence restarts at address 0.
- Reset asserted in `READY` with `CLEAR_ON_RESET`=1: re-clears the full array.
- Reset asserted with a read in flight: the read is dropped. No `rd_valid` pulse is produced for it.

## Timing

- Read request at edge N:
  - `OUT_REG`=0: `rd_data`/`rd_valid` valid after edge N+1.
  - `OUT_REG`=1: valid after edge N+2.
- Throughput: one read and one write per cycle, sustained. `rd_valid` follows `rd_en` delayed by the latency.
- Write at edge N is visible to a read issued at edge N+1 and later. Same-edge visibility is via the bypass only.
- Clear duration:
  - `busy` is high for exactly 2^ADDR_W cycles after the cycle in which `rst` deasserts.
  - First accepted request is on the first edge with `busy`=0.
- `busy` is a registered output. There is no combinational path from inputs to any output.

## Test plan

Benches use `DATA_W`=16, `ADDR_W`=4.
1. **Reset clear:** pulse `rst`, then count `busy` high cycles → exactly 16. Then read addresses 0..15 → all 0x0000, `rd_valid` high for 16 consecutive cycles.
2. **Byte enables:** write 0xABCD at address 3 with `wr_be`=2'b11, then 0x1234 with `wr_be`=2'b01, then read address 3 → 0xAB34 after 1 cycle (`OUT_REG`=0) and after 2 cycles (`OUT_REG`=1).
3. **Collision merge:** address 5 holds 0x5566. Same cycle: `we`=1, `wr_be`=2'b10, `wr_data`=0x99AA, `rd_en`=1, `rd_addr`=5 → `rd_data`=0x9966. A later read of address 5 → 0x9966.
4. **Back-to-back streaming:** write addresses 0..15 with data 0x0100+addr. Read 0..15 with `rd_en` held high, interleaving `rd_en`=0 gaps at addresses 4 and 9 → correct data in order; `rd_valid` low exactly in the gap cycles.
5. **Reset mid-operation:** assert `rst` at clear cycle 7 → `busy` stays high for 16 further cycles after release. Assert `rst` with a read in flight → no `rd_valid` pulse; `rd_data`=0.
6. **Requests during busy:** drive `we`=1 to address 2 with 0xFFFF and `rd_en`=1 during `CLEAR` → no `rd_valid`. Read address 2 after `busy` falls → 0x0000.
